// File: rtl/db15_pkg.sv
// Shared types and constants for the DB15 serial pad scanner.
// Button bit positions are the same in both joystick words.
package db15_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    COMMIT
  } state_e;

  localparam int DEF_BITS_PER_PAD = 12;
  localparam int CHAIN_BITS       = 2 * DEF_BITS_PER_PAD;

  // Word layout ----LS FEDCBAUDLR; the face "D" button is BTN_FD so it cannot be confused with down.
  localparam int BTN_R  = 0;
  localparam int BTN_L  = 1;
  localparam int BTN_D  = 2;
  localparam int BTN_U  = 3;
  localparam int BTN_A  = 4;
  localparam int BTN_B  = 5;
  localparam int BTN_C  = 6;
  localparam int BTN_FD = 7;
  localparam int BTN_E  = 8;
  localparam int BTN_F  = 9;
  localparam int BTN_S  = 10;
  localparam int BTN_LS = 11;

endpackage

// File: rtl/db15_serial_scan_if.sv
// Signal bundle between the DB15 scanner, the adapter pins and the joystick mux.
// frame_done is a one-cycle strobe: joystick1/joystick2 are valid and stable whenever it is high and until the next strobe (or until enable drops in IDLE, when they clear to zero).
interface db15_serial_scan_if;
  import db15_pkg::*;

  logic        enable;
  logic        joy_data;
  logic        joy_clk;
  logic        joy_load;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame_done;
  state_e      state;

  modport master (
    input  enable, joy_data,
    output joy_clk, joy_load, joystick1, joystick2, frame_done, state
  );

  modport slave (
    output enable, joy_data,
    input  joy_clk, joy_load, joystick1, joystick2, frame_done, state
  );

endinterface

// File: rtl/db15_tick_gen.sv
// Scan-rate tick divider: one-cycle tick every CLK_DIV clk cycles.
// hold freezes the count for the single commit cycle so frame timing stays an exact cycle count.
module db15_tick_gen #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic tick
);

  localparam int             W    = $clog2(CLK_DIV) + 1;
  localparam logic [W-1:0]   LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/db15_serial_scan.sv
// Scans two 12-button pads through the DB15 adapter's parallel-load shift chain
// and publishes complete frames as two active-high 16-bit joystick words.
module db15_serial_scan
  import db15_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int FRAME_TICKS  = 50,
  parameter int BITS_PER_PAD = DEF_BITS_PER_PAD
) (
  input logic               clk,
  input logic               reset,
  db15_serial_scan_if.master bus
);

  localparam int CHAIN = 2 * BITS_PER_PAD;
  localparam int KW    = $clog2(CHAIN - 1) + 1;
  localparam int FW    = $clog2(FRAME_TICKS - 1) + 1;

  localparam logic [KW-1:0] K_LAST = KW'(CHAIN - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FRAME_TICKS - 1);

  state_e           state;
  logic             tick;
  logic             hold;
  logic [1:0]       sync;
  logic             bit_in;
  logic [FW-1:0]    idle_cnt;
  logic [KW-1:0]    k;
  logic [CHAIN-1:0] shadow;

  assign hold      = (state == COMMIT);
  assign bus.state = state;

  db15_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .hold  (hold),
    .tick  (tick)
  );

  // joy_data comes straight off the connector pin; buttons pull it low.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], bus.joy_data};
    end
  end

  assign bit_in = ~sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idle_cnt       <= '0;
      k              <= '0;
      shadow         <= '0;
      bus.joy_clk    <= 1'b0;
      bus.joy_load   <= 1'b1;
      bus.joystick1  <= '0;
      bus.joystick2  <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.enable) begin
            bus.joystick1 <= '0;
            bus.joystick2 <= '0;
          end
          if (tick) begin
            if (idle_cnt == F_LAST) begin
              idle_cnt <= '0;
              if (bus.enable) begin
                bus.joy_load <= 1'b0;
                state        <= LOAD;
              end
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        LOAD: begin
          if (tick) begin
            bus.joy_load <= 1'b1;
            k            <= '0;
            state        <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          // Shift in from the top: after CHAIN samples the first bit sits at shadow[0].
          if (tick) begin
            shadow      <= {bit_in, shadow[CHAIN-1:1]};
            bus.joy_clk <= 1'b1;
            state       <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (tick) begin
            bus.joy_clk <= 1'b0;
            if (k == K_LAST) begin
              state <= COMMIT;
            end else begin
              k     <= k + 1'b1;
              state <= SHIFT_LO;
            end
          end
        end
        COMMIT: begin
          bus.joystick1  <= 16'(shadow[BITS_PER_PAD-1:0]);
          bus.joystick2  <= 16'(shadow[CHAIN-1:BITS_PER_PAD]);
          bus.frame_done <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_db15_serial_scan.sv
// Bench for db15_serial_scan: a two-pad 165-chain adapter model feeds the scanner,
// expected words are queued at each load strobe and compared at each frame_done.
module tb_db15_serial_scan;
  import db15_pkg::*;

  localparam int CLK_DIV     = 4;
  localparam int FRAME_TICKS = 2;
  localparam int FRAME_CYC   = (FRAME_TICKS + 1 + 2 * CHAIN_BITS) * CLK_DIV + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  db15_serial_scan_if bus ();

  db15_serial_scan #(
    .CLK_DIV      (CLK_DIV),
    .FRAME_TICKS  (FRAME_TICKS),
    .BITS_PER_PAD (DEF_BITS_PER_PAD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- adapter model ----------------
  logic [11:0]           p1        = '0;
  logic [11:0]           p2        = '0;
  logic                  present   = 1'b0;
  logic [CHAIN_BITS-1:0] chain     = '1;
  logic                  joy_clk_q = 1'b0;

  always @(posedge clk) begin
    joy_clk_q <= bus.joy_clk;
    if (!bus.joy_load)                   chain <= ~{p2, p1};
    else if (bus.joy_clk && !joy_clk_q)  chain <= {1'b1, chain[CHAIN_BITS-1:1]};
  end

  assign bus.joy_data = present ? chain[0] : 1'b1;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic        prev_load = 1'b1;
  logic        prev_clk  = 1'b0;
  logic [31:0] prev_out  = '0;
  int          load_lo   = 0;
  int          rises     = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      load_lo = 0;
      rises   = 0;
    end else begin
      if (!bus.joy_load) load_lo++;
      if (prev_load && !bus.joy_load)
        exp_q.push_back(present ? {4'h0, p2, 4'h0, p1} : 32'h0);
      if (!prev_clk && bus.joy_clk) rises++;
      if ({bus.joystick2, bus.joystick1} != prev_out && !bus.frame_done)
        check("no_partial_update", {bus.joystick2, bus.joystick1}, 32'h0);
      if (bus.frame_done) begin
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0)
          check("frame_words", {bus.joystick2, bus.joystick1}, exp_q.pop_front());
        check("load_low_cycles", load_lo, CLK_DIV);
        check("clk_rises", rises, CHAIN_BITS);
        load_lo = 0;
        rises   = 0;
      end
    end
    prev_load = bus.joy_load;
    prev_clk  = bus.joy_clk;
    prev_out  = {bus.joystick2, bus.joystick1};
  end

  // ---------------- driver tasks ----------------
  task automatic wait_frame(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < budget);
    check("frame_done_seen", bus.frame_done, 1'b1);
  endtask

  task automatic wait_rises(input int target, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rises < target && n < budget);
    check("rises_reached", 32'(rises >= target), 32'h1);
  endtask

  // ---------------- main sequence ----------------
  int t0;
  int falls;
  logic pl;

  initial begin
    bus.enable = 1'b0;
    reset      = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_joy_clk",    bus.joy_clk,    1'b0);
    check("rst_joy_load",   bus.joy_load,   1'b1);
    check("rst_joystick1",  bus.joystick1,  16'h0);
    check("rst_joystick2",  bus.joystick2,  16'h0);
    check("rst_frame_done", bus.frame_done, 1'b0);
    check("rst_state",      bus.state,      IDLE);

    // Adapter absent: all-zero frames with exact timing.
    bus.enable = 1'b1;
    reset      = 1'b0;
    wait_frame(FRAME_CYC + 20);
    check("first_done_cycle", cyc, FRAME_CYC);
    t0 = cyc;
    wait_frame(FRAME_CYC + 20);
    check("frame_spacing", cyc - t0, FRAME_CYC);
    check("absent_joystick1", bus.joystick1, 16'h0);

    // Known pattern.
    present = 1'b1;
    p1      = 12'h015;
    p2      = 12'h820;
    wait_frame(FRAME_CYC + 20);
    check("p1_word", bus.joystick1, 16'h0015);
    check("p2_word", bus.joystick2, 16'h0820);
    check("p1_btn_a",  bus.joystick1[BTN_A],  1'b1);
    check("p2_btn_ls", bus.joystick2[BTN_LS], 1'b1);

    // Pattern changes mid-shift: this frame keeps the old words, the next one picks up the new.
    wait_rises(6, FRAME_CYC * 2);
    p1 = 12'hA5C;
    p2 = 12'h3F1;
    wait_frame(FRAME_CYC + 20);
    check("old_frame_p1", bus.joystick1, 16'h0015);
    check("old_frame_p2", bus.joystick2, 16'h0820);
    wait_frame(FRAME_CYC + 20);
    check("new_frame_p1", bus.joystick1, 16'h0A5C);
    check("new_frame_p2", bus.joystick2, 16'h03F1);

    // Random patterns.
    repeat (3) begin
      p1 = 12'($urandom_range(0, 4095));
      p2 = 12'($urandom_range(0, 4095));
      wait_frame(FRAME_CYC + 20);
    end

    // Reset at bit 17 of a frame.
    p1 = 12'h015;
    p2 = 12'h820;
    wait_frame(FRAME_CYC + 20);
    wait_rises(17, FRAME_CYC * 2);
    reset = 1'b1;
    @(negedge clk);
    check("abort_joy_clk",   bus.joy_clk,   1'b0);
    check("abort_joy_load",  bus.joy_load,  1'b1);
    check("abort_joystick1", bus.joystick1, 16'h0);
    check("abort_joystick2", bus.joystick2, 16'h0);
    reset = 1'b0;
    wait_frame(FRAME_CYC + 20);
    check("post_reset_done_cycle", cyc, FRAME_CYC);
    check("post_reset_p1", bus.joystick1, 16'h0015);

    // Enable dropped mid-shift: frame commits, then outputs clear and scanning stops.
    wait_rises(5, FRAME_CYC * 2);
    bus.enable = 1'b0;
    wait_frame(FRAME_CYC + 20);
    check("disable_commit_p2", bus.joystick2, 16'h0820);
    @(negedge clk);
    check("disabled_joystick1", bus.joystick1, 16'h0);
    check("disabled_joystick2", bus.joystick2, 16'h0);
    check("disabled_joy_load",  bus.joy_load,  1'b1);
    falls = 0;
    pl    = bus.joy_load;
    repeat (300) begin
      @(negedge clk);
      if (pl && !bus.joy_load) falls++;
      pl = bus.joy_load;
    end
    check("no_load_while_disabled", falls, 0);
    bus.enable = 1'b1;
    wait_frame(FRAME_CYC * 3);
    check("resume_p1", bus.joystick1, 16'h0015);
    check("resume_p2", bus.joystick2, 16'h0820);

    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/db15_serial_scan.md
Name: db15_serial_scan

Overview:
- Upstream input stage for the UserIO DB15 adapter: serially scans two 12-button pads through the adapter's parallel-load shift-register chain.
- Drives the active-low load strobe and the shift clock, samples the serial data line, and publishes two 16-bit active-high joystick words.
- Bit layout of each word: ----LS FEDCBAUDLR.
- Consumer: the joystick mux in the core top level, gated by the UserIO joystick mode status bits.

Parameters:
- CLK_DIV, 1000, clk cycles per scan tick (>=2); 20 us at 50 MHz.
- FRAME_TICKS, 50, idle ticks between frames (>=1).
- BITS_PER_PAD, 12, serial bits per player; chain length is 2*BITS_PER_PAD.

Ports:
- clk  in  1  scan clock, 40-50 MHz domain
- reset  in  1  synchronous, active-high
- enable  in  1  1 = scanning allowed (DB15 mode selected)
- joy_data  in  1  serial data from adapter; asynchronous; active-low buttons
- joy_clk  out  1  shift clock to adapter; rising edge shifts the chain
- joy_load  out  1  parallel load to adapter, active-low
- joystick1  out  16  player 1 buttons, active-high, bits [15:12]=0
- joystick2  out  16  player 2 buttons, active-high, bits [15:12]=0
- frame_done  out  1  one-cycle pulse when both words update

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port clk, reset port reset.
- Reset values: joy_clk=0, joy_load=1, joystick1=joystick2=0, frame_done=0, state=IDLE, tick counter=0, synchroniser flops=1.
- tick: one-cycle pulse every CLK_DIV clk cycles, free-running from reset. All FSM transitions occur on tick cycles only.
- joy_data passes through a 2-FF synchroniser before sampling. Stored bit = ~synchronised joy_data.
- FSM:
  - IDLE: count FRAME_TICKS ticks. On the final tick, if enable=1, go to LOAD; otherwise restart the count.
  - LOAD: joy_load=0 for exactly 1 tick, then joy_load=1 and go to SHIFT_LO with k=0.
  - SHIFT_LO: joy_clk=0. On tick, sample stored bit into shadow[k], set joy_clk=1, go to SHIFT_HI.
  - SHIFT_HI: joy_clk=1. On tick, set joy_clk=0. If k=2*BITS_PER_PAD-1, go to COMMIT; else k=k+1 and go to SHIFT_LO.
  - COMMIT: single cycle, not tick-gated. Loads joystick1[11:0]=shadow[11:0] and joystick2[11:0]=shadow[23:12] on the same edge, pulses frame_done=1, then returns to IDLE.
- Bit k=0 is the first bit present after load, i.e. player 1 bit 0 (R). Bit 12 is player 2 bit 0.
- Outputs are registered and never change mid-frame. Consumers only see complete frames.
- Frame period = (FRAME_TICKS + 1 + 2*2*BITS_PER_PAD)*CLK_DIV + 1 cycles.
- enable deasserted mid-frame: the current frame completes and commits. enable is only checked in IDLE.
- enable=0 in IDLE: joystick1 and joystick2 clear to 0 on the next cycle; joy_clk=0, joy_load=1.
- Reset mid-frame: abort immediately to reset values. The partial shadow is discarded; the first frame after reset is a full frame.
- Adapter absent (joy_data floats high): every frame commits all zeros and is not an error.
- Counter widths: $clog2 of their maximum value plus 1. No wrap aliasing; the tick counter resets to 0 on reaching CLK_DIV-1.

Decomposition:
- Package db15_pkg holds:
  - state enum {IDLE, LOAD, SHIFT_LO, SHIFT_HI, COMMIT};
  - localparam CHAIN_BITS = 2*BITS_PER_PAD;
  - bit-index constants BTN_R=0, BTN_L=1, BTN_D=2, BTN_U=3, BTN_A=4 ... BTN_S=10, BTN_LS=11.
- One sub-module: db15_tick_gen (CLK_DIV counter producing tick; same clk/reset).

Test Plan:
- Reset then run with CLK_DIV=4, FRAME_TICKS=2, joy_data held high -> joy_load low exactly 4 cycles per frame; 24 joy_clk rising edges per frame; frame_done at the expected cycle; outputs 0x0000.
- Adapter model (two 12-bit 165 chains) with p1 buttons 0x015 and p2 buttons 0x820 pressed (driven low) -> after frame_done, joystick1=0x0015 and joystick2=0x0820.
- Change the adapter pattern mid-shift (after bit 5) -> outputs unchanged until the next frame_done; no partial update at any cycle.
- Assert reset at bit 17 of a frame -> next cycle joy_clk=0, joy_load=1, outputs 0. The next frame completes with correct values.
- Drop enable during SHIFT -> the frame commits normally; next cycle in IDLE the outputs become 0. No joy_load pulses while enable=0; scanning resumes on re-enable.
- Measure frame_done spacing with CLK_DIV=4, FRAME_TICKS=2 -> (2+1+48)*4+1 = 205 cycles.
